seq_mult_operand_ctrl: RTL

Parametrised, registered successor to the combinational load-control stage of the sequential shift-add multiplier. It accepts two operands through a valid/ready handshake and supports a signed (two's complement) or unsigned mode. It converts the operands to magnitudes, launches the shift-add core and waits for it to finish. It then applies the deferred two's-complement correction to the raw product and presents the result through a second valid/ready handshake, with a watchdog on the core.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/sign_magnitude_conv.sv | 24 ++
 rtl/seq_mult_operand_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier operand control.
// Contents:
//   DEFAULT_WORD_LENGTH - default operand width
//   state_t             - control FSM states (IDLE, START, WAIT, DONE)
//   compute_negate      - result sign: set when the signed operands differ in sign
package mult_pkg;

  localparam int DEFAULT_WORD_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The core multiplies magnitudes.
  // The final product needs negating only when exactly one signed operand is negative.
  function automatic logic compute_negate(input logic signed_mode,
                                          input logic sign_a,
                                          input logic sign_b);
    return signed_mode & (sign_a ^ sign_b);
  endfunction

endpackage

// File: rtl/sign_magnitude_conv.sv
// Combinational two's complement to magnitude converter, one per operand.
// Ports:
//   value       - operand as presented on the input handshake
//   signed_mode - 1: value is two's complement, 0: value is unsigned
//   magnitude   - absolute value as an unsigned WORD_LENGTH-bit number
//   sign        - 1 when the operand is a negative signed value
module sign_magnitude_conv
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic [WORD_LENGTH-1:0] value,
  input  logic                   signed_mode,
  output logic [WORD_LENGTH-1:0] magnitude,
  output logic                   sign
);

  assign sign = signed_mode & value[WORD_LENGTH-1];

  // The most-negative value negates to itself.
  // Read as unsigned, that is exactly 2^(WORD_LENGTH-1), the correct magnitude.
  assign magnitude = sign ? (~value + WORD_LENGTH'(1)) : value;

endmodule

// File: rtl/seq_mult_operand_ctrl.sv
// Registered load/sequence controller for the sequential shift-add multiplier.
// The controller:
//   - accepts an operand pair on an input valid/ready handshake;
//   - hands the operand magnitudes to the core and waits for core_done, guarded by a watchdog;
//   - applies the deferred sign correction;
//   - presents the result on an output valid/ready handshake.
// Ports:
//   clk, rst                          - clock (rising edge), async active-low reset
//   in_valid/in_ready                 - operand handshake (ready only in IDLE)
//   multiplicand_in, multiplier_in    - operands
//   signed_mode                       - two's complement mode, sampled with operands
//   core_start                        - one-cycle launch pulse to the core
//   core_multiplicand                 - zero-extended multiplicand magnitude
//   core_multiplier                   - multiplier magnitude
//   core_done, core_product           - core completion pulse and unsigned product
//   out_valid/out_ready               - result handshake
//   product_out                       - final product
//   error                             - qualifies out_valid, 1 = core timeout
//   busy                              - high whenever not IDLE
module seq_mult_operand_ctrl
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int MAX_WAIT    = 2 * WORD_LENGTH + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_LENGTH-1:0]     multiplicand_in,
  input  logic [WORD_LENGTH-1:0]     multiplier_in,
  input  logic                       signed_mode,
  output logic                       core_start,
  output logic [2*WORD_LENGTH-1:0]   core_multiplicand,
  output logic [WORD_LENGTH-1:0]     core_multiplier,
  input  logic                       core_done,
  input  logic [2*WORD_LENGTH-1:0]   core_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WORD_LENGTH-1:0]   product_out,
  output logic                       error,
  output logic                       busy
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t state;
  state_t next_state;

  logic [WORD_LENGTH-1:0] mag_a;
  logic [WORD_LENGTH-1:0] mag_b;
  logic                   sign_a;
  logic                   sign_b;
  logic                   negate;
  logic [CW-1:0]          wait_count;
  logic                   wait_limit;
  logic                   load;

  sign_magnitude_conv #(.WORD_LENGTH(WORD_LENGTH)) u_conv_a (
    .value       (multiplicand_in),
    .signed_mode (signed_mode),
    .magnitude   (mag_a),
    .sign        (sign_a)
  );

  sign_magnitude_conv #(.WORD_LENGTH(WORD_LENGTH)) u_conv_b (
    .value       (multiplier_in),
    .signed_mode (signed_mode),
    .magnitude   (mag_b),
    .sign        (sign_b)
  );

  assign load = in_valid && (state == IDLE);

  // The counter restarts at 0 on WAIT entry.
  // Firing at MAX_WAIT-1 therefore gives exactly MAX_WAIT cycles in WAIT.
  assign wait_limit = (wait_count == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = START;
      end
      START: begin
        core_start = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (core_done || wait_limit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers.
  // Operands load only on the IDLE handshake.
  // The result loads only while in WAIT, so it stays frozen through DONE backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_multiplicand <= '0;
      core_multiplier   <= '0;
      negate            <= 1'b0;
      wait_count        <= '0;
      product_out       <= '0;
      error             <= 1'b0;
    end else begin
      if (load) begin
        core_multiplicand <= {{WORD_LENGTH{1'b0}}, mag_a};
        core_multiplier   <= mag_b;
        negate            <= compute_negate(signed_mode, sign_a, sign_b);
      end
      if (state == START) begin
        wait_count <= '0;
      end else if (state == WAIT) begin
        // core_done takes priority over a simultaneous timeout
        if (core_done) begin
          product_out <= negate ? (~core_product + PW'(1)) : core_product;
          error       <= 1'b0;
        end else if (wait_limit) begin
          product_out <= '0;
          error       <= 1'b1;
        end else begin
          wait_count <= wait_count + CW'(1);
        end
      end
    end
  end

endmodule
